// File: rtl/nmi_conditioner.sv
// nmi_conditioner: turns CHANNELS raw active-low NMI sources into one Z80 NMI pulse.
// Each source is synchronised, debounced and edge-captured. All captured edges
// merge into one fixed-width NMI pulse. Every pulse is followed by a hold-off window.
// Ports:
//   CLK       system clock, rising edge
//   RESETN    synchronous active-low reset
//   NMIN_SRC  raw active-low sources, asynchronous to CLK
//   EN        per-channel enable; low clears pending and blocks capture
//   CLR       per-channel one-cycle clear strobe for CAUSE/OVR
//   NMI       registered active-low NMI to the CPU
//   CAUSE     sticky: channel contributed to an NMI pulse
//   OVR       sticky: edge arrived while the channel was already pending
//   BUSY      high while a pulse or hold-off window is in progress
module nmi_conditioner #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PULSE_CYCLES    = 8,
    parameter int unsigned HOLDOFF_CYCLES  = 32
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [CHANNELS-1:0] NMIN_SRC,
    input  logic [CHANNELS-1:0] EN,
    input  logic [CHANNELS-1:0] CLR,
    output logic                NMI,
    output logic [CHANNELS-1:0] CAUSE,
    output logic [CHANNELS-1:0] OVR,
    output logic                BUSY
);

    localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CW   = $clog2(TMAX + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    // Only used when a hold-off window exists; avoids an underflowed load otherwise
    localparam logic [CW-1:0]  HOLD_LOAD  = CW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    logic [CHANNELS-1:0]          sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]          s_c;
    logic [CHANNELS-1:0]          stable_q, stable_d;
    logic [CHANNELS-1:0][DBW-1:0] dcnt_q, dcnt_d;
    logic [CHANNELS-1:0]          fall_c;
    logic [CHANNELS-1:0]          pending_q, pending_d;
    logic [CHANNELS-1:0]          cause_q, cause_d;
    logic [CHANNELS-1:0]          ovr_q, ovr_d;
    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         nmi_q, nmi_d;
    logic                         busy_q, busy_d;
    logic                         consume_c;

    // Synchroniser chain per channel; idle level is high
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
        end else begin
            sync_q[0] <= NMIN_SRC;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s_c = sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        fall_c   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s_c[i] == stable_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DB_LAST) begin
                stable_d[i] = s_c[i];
                dcnt_d[i]   = '0;
                // s differs from stable, so an old level of 1 means a 1->0 transition
                fall_c[i]   = stable_q[i];
            end else begin
                dcnt_d[i] = dcnt_q[i] + DBW'(1);
            end
        end
    end

    // Pulse / hold-off sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nmi_d     = nmi_q;
        busy_d    = busy_q;
        consume_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    consume_c = 1'b1;
                    nmi_d     = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = PULSE_LOAD;
                    state_d   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    nmi_d = 1'b1;
                    if (HOLDOFF_CYCLES == 0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLDOFF;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                nmi_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending and sticky flags; a fresh edge beats a same-cycle consume, a set beats CLR
    always_comb begin
        pending_d = EN & ((pending_q & ~{CHANNELS{consume_c}}) | fall_c);
        ovr_d     = (ovr_q & ~CLR) | (EN & fall_c & pending_q & ~{CHANNELS{consume_c}});
        cause_d   = (cause_q & ~CLR) | (consume_c ? pending_q : '0);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            stable_q  <= '1;
            dcnt_q    <= '0;
            pending_q <= '0;
            cause_q   <= '0;
            ovr_q     <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            nmi_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            dcnt_q    <= dcnt_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nmi_q     <= nmi_d;
            busy_q    <= busy_d;
        end
    end

    assign NMI   = nmi_q;
    assign BUSY  = busy_q;
    assign CAUSE = cause_q;
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_nmi_conditioner.sv
// Bench for nmi_conditioner with default parameters: expected NMI pulses are queued
// when stimulus is driven and checked by a monitor when NMI actually falls.
module tb_nmi_conditioner;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] nmin_src;
    logic [1:0] en;
    logic [1:0] clr;
    logic       nmi;
    logic       busy;
    logic [1:0] cause;
    logic [1:0] ovr;

    always #5 clk = ~clk;

    nmi_conditioner dut (
        .CLK      (clk),
        .RESETN   (resetn),
        .NMIN_SRC (nmin_src),
        .EN       (en),
        .CLR      (clr),
        .NMI      (nmi),
        .CAUSE    (cause),
        .OVR      (ovr),
        .BUSY     (busy)
    );

    // Number of rising edges so far; at a falling edge this is the last edge's number
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int         start;
        logic [1:0] cause;
        int         width;
        int         busy_len;
    } exp_t;

    exp_t sb[$];
    int   pushed = 0;
    int   pulses = 0;

    function automatic void expect_pulse(input int start, input logic [1:0] c,
                                         input int width, input int busy_len);
        exp_t e;
        e.start    = start;
        e.cause    = c;
        e.width    = width;
        e.busy_len = busy_len;
        sb.push_back(e);
        pushed++;
    endfunction

    // Monitor: pop an expectation on each NMI fall, then time the pulse and busy window
    logic prev_nmi  = 1'b1;
    logic prev_busy = 1'b0;
    exp_t cur;
    bit   have_cur = 1'b0;
    int   t0 = 0;

    always @(negedge clk) begin
        if (prev_nmi === 1'b1 && nmi === 1'b0) begin
            pulses++;
            if (sb.size() > 0) begin
                cur      = sb.pop_front();
                have_cur = 1'b1;
                t0       = cyc;
                check("nmi_start", 32'(cyc), 32'(cur.start));
                check("cause_at_pulse", 32'(cause), 32'(cur.cause));
                check("busy_at_pulse", 32'(busy), 32'd1);
            end else begin
                have_cur = 1'b0;
                check("unexpected_pulse_cycle", 32'(cyc), 32'd0);
            end
        end
        if (have_cur && prev_nmi === 1'b0 && nmi === 1'b1)
            check("nmi_width", 32'(cyc - t0), 32'(cur.width));
        if (have_cur && prev_busy === 1'b1 && busy === 1'b0) begin
            check("busy_len", 32'(cyc - t0), 32'(cur.busy_len));
            have_cur = 1'b0;
        end
        prev_nmi  = nmi;
        prev_busy = busy;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [1:0] m);
        clr = m;
        wait_clk(1);
        clr = 2'b00;
    endtask

    int n;

    initial begin
        resetn   = 1'b0;
        nmin_src = 2'b11;
        en       = 2'b00;
        clr      = 2'b00;
        wait_clk(3);
        check("rst_nmi", 32'(nmi), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        resetn = 1'b1;
        wait_clk(20);

        // Single press on channel 0
        en = 2'b01;
        n = cyc;
        nmin_src[0] = 1'b0;
        expect_pulse(n + 19, 2'b01, 8, 40);
        wait_clk(100);
        nmin_src[0] = 1'b1;
        wait_clk(60);
        check("s1_cause", 32'(cause), 32'd1);
        check("s1_ovr", 32'(ovr), 32'd0);
        check("s1_nmi_idle", 32'(nmi), 32'd1);
        check("s1_pulses", 32'(pulses), 32'(pushed));
        pulse_clr(2'b01);
        check("s1_cause_clr", 32'(cause), 32'd0);

        // Glitch of 15 clocks is rejected, 16 clocks is accepted
        nmin_src[0] = 1'b0;
        wait_clk(15);
        nmin_src[0] = 1'b1;
        wait_clk(60);
        check("s2_glitch_pulses", 32'(pulses), 32'(pushed));
        check("s2_glitch_cause", 32'(cause), 32'd0);
        n = cyc;
        nmin_src[0] = 1'b0;
        expect_pulse(n + 19, 2'b01, 8, 40);
        wait_clk(16);
        nmin_src[0] = 1'b1;
        wait_clk(80);
        check("s2_pulses", 32'(pulses), 32'(pushed));
        pulse_clr(2'b01);

        // Merge and hold-off: ch1 edge during the first pulse yields a second pulse after hold-off
        en = 2'b11;
        n = cyc;
        nmin_src[0] = 1'b0;
        expect_pulse(n + 19, 2'b01, 8, 40);
        wait_clk(10);
        nmin_src[1] = 1'b0;
        expect_pulse(n + 60, 2'b11, 8, 40);
        wait_clk(110);
        nmin_src = 2'b11;
        wait_clk(60);
        check("s3_pulses", 32'(pulses), 32'(pushed));
        check("s3_cause", 32'(cause), 32'd3);
        check("s3_ovr", 32'(ovr), 32'd0);
        pulse_clr(2'b11);

        // Overrun: ch1 starts a pulse, ch0 falls twice while busy
        n = cyc;
        nmin_src[1] = 1'b0;
        expect_pulse(n + 19, 2'b10, 8, 40);
        wait_clk(5);
        nmin_src[0] = 1'b0;
        wait_clk(16);
        nmin_src[0] = 1'b1;
        wait_clk(16);
        nmin_src[0] = 1'b0;
        expect_pulse(n + 60, 2'b11, 8, 40);
        wait_clk(80);
        check("s4_pulses", 32'(pulses), 32'(pushed));
        check("s4_ovr", 32'(ovr), 32'd1);
        check("s4_cause", 32'(cause), 32'd3);
        pulse_clr(2'b01);
        check("s4_cause_clr", 32'(cause), 32'd2);
        check("s4_ovr_clr", 32'(ovr), 32'd0);
        nmin_src = 2'b11;
        wait_clk(60);
        check("s4_release_pulses", 32'(pulses), 32'(pushed));
        pulse_clr(2'b10);
        check("s4_cause_clr1", 32'(cause), 32'd0);

        // Enable gating: edge with EN low is dropped and not replayed
        en = 2'b00;
        nmin_src[0] = 1'b0;
        wait_clk(40);
        en = 2'b01;
        wait_clk(60);
        check("s5_pulses", 32'(pulses), 32'(pushed));
        check("s5_cause", 32'(cause), 32'd0);
        nmin_src[0] = 1'b1;
        wait_clk(40);
        check("s5_release_pulses", 32'(pulses), 32'(pushed));

        // Reset on the 4th NMI-low clock
        n = cyc;
        nmin_src[0] = 1'b0;
        expect_pulse(n + 19, 2'b01, 3, 3);
        wait_clk(21);
        resetn = 1'b0;
        en     = 2'b00;
        wait_clk(1);
        check("s6_rst_nmi", 32'(nmi), 32'd1);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_cause", 32'(cause), 32'd0);
        wait_clk(1);
        resetn = 1'b1;
        wait_clk(40);
        check("s6_noen_pulses", 32'(pulses), 32'(pushed));
        check("s6_noen_cause", 32'(cause), 32'd0);

        // Reset again with EN set: the held-low source fires once after release
        resetn = 1'b0;
        en     = 2'b01;
        wait_clk(1);
        resetn = 1'b1;
        n = cyc;
        expect_pulse(n + 19, 2'b01, 8, 40);
        wait_clk(80);
        check("s6_en_pulses", 32'(pulses), 32'(pushed));
        check("s6_en_cause", 32'(cause), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
